// File: rtl/reg_file_ctrl.sv
// Command decoder between the UART RX byte stream and the 16x8 register file.
// Handles AA/addr/data writes and BB/addr reads, and forwards read data to the TX FIFO.
module reg_file_ctrl #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
  parameter int                    RD_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  FIFO_FULL,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR,
  output logic                  BUSY
);

  localparam int             CNT_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_cmd_err;

  logic w_err;
  logic w_addr_ld;
  logic w_wdata_ld;
  logic w_cap;
  logic w_cnt_clr;
  logic w_cnt_inc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx_data <= '0;
      r_cnt     <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cmd_err <= w_err;
      if (w_addr_ld)  r_addr    <= RX_P_DATA[ADDR_WIDTH-1:0];
      if (w_wdata_ld) r_wdata   <= RX_P_DATA;
      if (w_cap)      r_tx_data <= RdData;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_ONE;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_err        = 1'b0;
    w_addr_ld    = 1'b0;
    w_wdata_ld   = 1'b0;
    w_cap        = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD)      w_state_next = WR_ADDR;
          else if (RX_P_DATA == RD_CMD) w_state_next = RD_ADDR;
          else                          w_err        = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          w_addr_ld    = 1'b1;
          w_state_next = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          w_wdata_ld   = 1'b1;
          w_state_next = WR_EXEC;
        end
      end
      WR_EXEC: begin
        w_err        = RX_D_VLD;
        w_state_next = IDLE;
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          w_addr_ld    = 1'b1;
          w_state_next = RD_EXEC;
        end
      end
      RD_EXEC: begin
        w_err        = RX_D_VLD;
        w_cnt_clr    = 1'b1;
        w_state_next = RD_WAIT;
      end
      RD_WAIT: begin
        // A dropped byte and a timeout in the same cycle merge into one pulse.
        w_err = RX_D_VLD;
        if (RdData_Valid) begin
          w_cap        = 1'b1;
          w_state_next = TX_SEND;
        end else begin
          w_cnt_inc = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_err        = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      TX_SEND: begin
        w_err = RX_D_VLD;
        if (!FIFO_FULL) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign WrEn      = (r_state == WR_EXEC);
  assign RdEn      = (r_state == RD_EXEC);
  // The FIFO strobe is held off while full so the byte waits in TX_SEND.
  assign TX_D_VLD  = (r_state == TX_SEND) && !FIFO_FULL;
  assign BUSY      = (r_state != IDLE);
  assign Address   = r_addr;
  assign WrData    = r_wdata;
  assign TX_P_DATA = r_tx_data;
  assign CMD_ERR   = r_cmd_err;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl with a small behavioural register file
// (REG2=81, REG3=20 after reset, one-cycle read latency).
module tb_reg_file_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       FIFO_FULL;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       CMD_ERR;
  logic       BUSY;

  int tests = 0;
  int fails = 0;
  int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0, n_both = 0;
  logic rd_suppress;
  logic [7:0] mem [16];

  reg_file_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .FIFO_FULL(FIFO_FULL),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem[2]       <= 8'h81;
      mem[3]       <= 8'h20;
      RdData       <= 8'h00;
      RdData_Valid <= 1'b0;
    end else begin
      RdData_Valid <= RdEn && !rd_suppress;
      if (RdEn) RdData <= mem[Address];
      if (WrEn) mem[Address] <= WrData;
    end
  end

  always @(negedge CLK) begin
    if (WrEn)          n_wr   <= n_wr + 1;
    if (RdEn)          n_rd   <= n_rd + 1;
    if (TX_D_VLD)      n_tx   <= n_tx + 1;
    if (CMD_ERR)       n_err  <= n_err + 1;
    if (WrEn && RdEn)  n_both <= n_both + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    tick();
    tests++; if ({WrEn, RdEn, TX_D_VLD, CMD_ERR, BUSY} !== 5'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 00000", {WrEn, RdEn, TX_D_VLD, CMD_ERR, BUSY}); end
    tests++; if ({Address, WrData, TX_P_DATA} !== 20'h0) begin fails++; $display("FAIL reset_data: got %h want 00000", {Address, WrData, TX_P_DATA}); end
    RST = 1'b1;
    tick();
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_idle: BUSY got %b want 0", BUSY); end
    $display("[TB] reset checked");
  endtask

  task automatic test_read_default();
    int rd0 = n_rd;
    int tx0 = n_tx;
    send_byte(8'hBB);
    send_byte(8'h02);
    tests++; if ({RdEn, WrEn, BUSY} !== 3'b101) begin fails++; $display("FAIL rd2_rden: {RdEn,WrEn,BUSY} got %b want 101", {RdEn, WrEn, BUSY}); end
    tests++; if (Address !== 4'h2) begin fails++; $display("FAIL rd2_addr: got %h want 2", Address); end
    tick();
    tests++; if ({RdEn, TX_D_VLD, BUSY} !== 3'b001) begin fails++; $display("FAIL rd2_wait: {RdEn,TX_D_VLD,BUSY} got %b want 001", {RdEn, TX_D_VLD, BUSY}); end
    tick();
    tests++; if (TX_D_VLD !== 1'b1) begin fails++; $display("FAIL rd2_txvld: got %b want 1", TX_D_VLD); end
    tests++; if (TX_P_DATA !== 8'h81) begin fails++; $display("FAIL rd2_txdata: got %h want 81", TX_P_DATA); end
    tick();
    tests++; if ({TX_D_VLD, BUSY} !== 2'b00) begin fails++; $display("FAIL rd2_done: {TX_D_VLD,BUSY} got %b want 00", {TX_D_VLD, BUSY}); end
    tests++; if ((n_rd - rd0) != 1 || (n_tx - tx0) != 1) begin fails++; $display("FAIL rd2_pulses: rd %0d tx %0d want 1 1", n_rd - rd0, n_tx - tx0); end
    $display("[TB] read REG2 -> %h", TX_P_DATA);
  endtask

  task automatic test_write_read();
    int wr0 = n_wr;
    send_byte(8'hAA);
    send_byte(8'h05);
    tests++; if (WrEn !== 1'b0) begin fails++; $display("FAIL wr_early: WrEn got %b want 0", WrEn); end
    send_byte(8'h3C);
    tests++; if ({WrEn, RdEn} !== 2'b10) begin fails++; $display("FAIL wr_en: {WrEn,RdEn} got %b want 10", {WrEn, RdEn}); end
    tests++; if ({Address, WrData} !== 12'h53C) begin fails++; $display("FAIL wr_addr_data: got %h want 53c", {Address, WrData}); end
    tick();
    tests++; if ({WrEn, BUSY} !== 2'b00) begin fails++; $display("FAIL wr_done: {WrEn,BUSY} got %b want 00", {WrEn, BUSY}); end
    tests++; if ((n_wr - wr0) != 1) begin fails++; $display("FAIL wr_count: got %0d want 1", n_wr - wr0); end
    send_byte(8'hBB);
    send_byte(8'h05);
    for (int i = 0; i < 10 && !TX_D_VLD; i++) tick();
    tests++; if (TX_D_VLD !== 1'b1) begin fails++; $display("FAIL wr_rb_timeout: TX_D_VLD got %b want 1", TX_D_VLD); end
    tests++; if (TX_P_DATA !== 8'h3C) begin fails++; $display("FAIL wr_readback: got %h want 3c", TX_P_DATA); end
    tick();
    $display("[TB] write 5<=3c, readback %h", TX_P_DATA);
  endtask

  task automatic test_bad_opcode();
    int err0 = n_err;
    send_byte(8'h55);
    tests++; if ({CMD_ERR, WrEn, RdEn, TX_D_VLD, BUSY} !== 5'b10000) begin fails++; $display("FAIL bad_op: {CMD_ERR,WrEn,RdEn,TX,BUSY} got %b want 10000", {CMD_ERR, WrEn, RdEn, TX_D_VLD, BUSY}); end
    tick();
    tests++; if ({CMD_ERR, BUSY} !== 2'b00) begin fails++; $display("FAIL bad_op_end: {CMD_ERR,BUSY} got %b want 00", {CMD_ERR, BUSY}); end
    tests++; if ((n_err - err0) != 1) begin fails++; $display("FAIL bad_op_count: got %0d want 1", n_err - err0); end
    $display("[TB] bad opcode 55 -> one CMD_ERR");
  endtask

  task automatic test_fifo_full();
    int tx0 = n_tx;
    logic bad = 1'b0;
    FIFO_FULL = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h03);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      if (TX_D_VLD !== 1'b0 || BUSY !== 1'b1) bad = 1'b1;
      tick();
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL full_hold: TX_D_VLD/BUSY wrong while full, got %b want 0", bad); end
    FIFO_FULL = 1'b0;
    #1;
    tests++; if (TX_D_VLD !== 1'b1) begin fails++; $display("FAIL full_release: TX_D_VLD got %b want 1", TX_D_VLD); end
    tests++; if (TX_P_DATA !== 8'h20) begin fails++; $display("FAIL full_data: got %h want 20", TX_P_DATA); end
    tick();
    tests++; if ({TX_D_VLD, BUSY} !== 2'b00) begin fails++; $display("FAIL full_done: {TX_D_VLD,BUSY} got %b want 00", {TX_D_VLD, BUSY}); end
    tests++; if ((n_tx - tx0) != 1) begin fails++; $display("FAIL full_count: got %0d want 1", n_tx - tx0); end
    $display("[TB] fifo full hold then send %h", TX_P_DATA);
  endtask

  task automatic test_timeout();
    int tx0 = n_tx;
    int err0 = n_err;
    rd_suppress = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h01);
    tick();
    tick();
    tick();
    tick();
    tests++; if ({BUSY, CMD_ERR} !== 2'b10) begin fails++; $display("FAIL to_wait: {BUSY,CMD_ERR} got %b want 10", {BUSY, CMD_ERR}); end
    tick();
    tests++; if ({BUSY, CMD_ERR} !== 2'b01) begin fails++; $display("FAIL to_err: {BUSY,CMD_ERR} got %b want 01", {BUSY, CMD_ERR}); end
    tick();
    tests++; if (CMD_ERR !== 1'b0) begin fails++; $display("FAIL to_pulse: CMD_ERR got %b want 0", CMD_ERR); end
    tests++; if ((n_tx - tx0) != 0 || (n_err - err0) != 1) begin fails++; $display("FAIL to_count: tx %0d err %0d want 0 1", n_tx - tx0, n_err - err0); end
    rd_suppress = 1'b0;
    $display("[TB] read timeout -> CMD_ERR");
  endtask

  task automatic test_reset_mid_cmd();
    int wr0 = n_wr;
    send_byte(8'hAA);
    send_byte(8'h07);
    RST = 1'b0;
    #1;
    tests++; if ({WrEn, RdEn, TX_D_VLD, CMD_ERR, BUSY} !== 5'b0) begin fails++; $display("FAIL rstmid_async: got %b want 00000", {WrEn, RdEn, TX_D_VLD, CMD_ERR, BUSY}); end
    tick();
    tick();
    RST = 1'b1;
    tick();
    tests++; if ({Address, WrData, BUSY} !== 13'h0) begin fails++; $display("FAIL rstmid_clear: got %h want 0000", {Address, WrData, BUSY}); end
    tests++; if ((n_wr - wr0) != 0) begin fails++; $display("FAIL rstmid_nowr: got %0d want 0", n_wr - wr0); end
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'h11);
    tests++; if ({WrEn, Address, WrData} !== 13'h1711) begin fails++; $display("FAIL rstmid_wr: got %h want 1711", {WrEn, Address, WrData}); end
    tick();
    $display("[TB] reset mid-command, rewrite 7<=11");
  endtask

  task automatic test_dropped_byte();
    int wr0 = n_wr;
    int err0 = n_err;
    send_byte(8'hAA);
    send_byte(8'hF6);
    send_byte(8'h77);
    tests++; if ({WrEn, Address, WrData} !== 13'h1677) begin fails++; $display("FAIL drop_wrap: got %h want 1677", {WrEn, Address, WrData}); end
    send_byte(8'h99);
    tests++; if ({CMD_ERR, BUSY, WrEn} !== 3'b100) begin fails++; $display("FAIL drop_err: {CMD_ERR,BUSY,WrEn} got %b want 100", {CMD_ERR, BUSY, WrEn}); end
    tick();
    tests++; if ((n_wr - wr0) != 1 || (n_err - err0) != 1) begin fails++; $display("FAIL drop_count: wr %0d err %0d want 1 1", n_wr - wr0, n_err - err0); end
    $display("[TB] byte dropped in WR_EXEC, address wrapped to 6");
  endtask

  task automatic test_back_to_back();
    send_byte(8'hAA);
    send_byte(8'h0A);
    send_byte(8'h5A);
    tick();
    send_byte(8'hBB);
    tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL b2b_accept: BUSY got %b want 1", BUSY); end
    send_byte(8'h0A);
    tick();
    tick();
    tests++; if ({TX_D_VLD, TX_P_DATA} !== 9'h15A) begin fails++; $display("FAIL b2b_read: got %h want 15a", {TX_D_VLD, TX_P_DATA}); end
    tick();
    tests++; if (n_both != 0) begin fails++; $display("FAIL wr_rd_overlap: got %0d want 0", n_both); end
    $display("[TB] back-to-back write/read -> %h", TX_P_DATA);
  endtask

  initial begin
    RST = 1'b0;
    RX_P_DATA = 8'h00;
    RX_D_VLD = 1'b0;
    FIFO_FULL = 1'b0;
    rd_suppress = 1'b0;
    test_reset();
    test_read_default();
    test_write_read();
    test_bad_opcode();
    test_fifo_full();
    test_timeout();
    test_reset_mid_cmd();
    test_dropped_byte();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Command-side initiator for the 16x8 register file.
- Consumes a received byte stream, decodes write and read commands, and drives WrEn/RdEn/Address/WrData into the register file.
- Captures RdData on RdData_Valid and forwards it as one byte to the TX FIFO write port.
- Sits between the UART RX data-sync output and the register file / TX FIFO, all in the reference clock domain.

Parameters:
ADDR_WIDTH, 4, register-file address width
DATA_WIDTH, 8, byte/data width
WR_CMD, 8'hAA, opcode for a register write
RD_CMD, 8'hBB, opcode for a register read
RD_TIMEOUT, 4, max cycles to wait in RD_WAIT for RdData_Valid (≥2)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active low
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
RdData  in  DATA_WIDTH  register-file read data
RdData_Valid  in  1  register-file read-data valid
FIFO_FULL  in  1  TX FIFO full
WrEn  out  1  register-file write enable
RdEn  out  1  register-file read enable
Address  out  ADDR_WIDTH  register-file address
WrData  out  DATA_WIDTH  register-file write data
TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe
CMD_ERR  out  1  one-cycle error pulse
BUSY  out  1  high when state != IDLE

Behaviour:
- Reset (RST low, async): state=IDLE, all outputs 0. Address, WrData and the capture register clear to 0. Timeout counter clears.
- Reset mid-command abandons the command; no WrEn/RdEn/TX_D_VLD is issued for it.
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND. All registered; WrEn, RdEn, TX_D_VLD, BUSY are Moore decodes of the state register.
- IDLE, on RX_D_VLD:
  - byte==WR_CMD -> WR_ADDR.
  - byte==RD_CMD -> RD_ADDR.
  - any other byte -> CMD_ERR pulse next cycle, stay IDLE.
- WR_ADDR: on RX_D_VLD, Address<=byte[ADDR_WIDTH-1:0] (upper bits ignored) -> WR_DATA.
- WR_DATA: on RX_D_VLD, WrData<=byte -> WR_EXEC.
- WR_EXEC: WrEn=1, RdEn=0 for exactly one cycle -> IDLE.
  - Data byte sampled at edge k; register file writes at edge k+1.
- RD_ADDR: on RX_D_VLD, latch Address -> RD_EXEC.
- RD_EXEC: RdEn=1, WrEn=0 for exactly one cycle -> RD_WAIT; clear timeout counter.
- RD_WAIT:
  - RdData_Valid=1: capture RdData into TX_P_DATA -> TX_SEND.
  - Otherwise increment the counter. When the counter reaches RD_TIMEOUT: CMD_ERR pulse -> IDLE.
- TX_SEND:
  - FIFO_FULL=0: TX_D_VLD=1 for one cycle -> IDLE.
  - FIFO_FULL=1: hold state; TX_D_VLD=0; TX_P_DATA stable.
- Nominal read latency: address byte at edge k; RdEn high in cycle k; RdData_Valid high in cycle k+1; TX_D_VLD high in cycle k+2.
- WrEn and RdEn are never high together.
- Address and WrData hold their last value outside EXEC states.
- RX_D_VLD in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND: byte dropped, CMD_ERR pulse, state unaffected.
- CMD_ERR is a single-cycle pulse per event. Simultaneous dropped-byte and timeout produce one pulse.
- Address wraps naturally within ADDR_WIDTH; no range check.
- Back-to-back commands: a new opcode is accepted on the first cycle back in IDLE.

Test Plan:
1. Bytes AA,05,3C -> exactly one WrEn pulse, cycle after 3C, with Address=5, WrData=3C; a later BB,05 returns TX_P_DATA=3C.
2. After reset, bytes BB,02 -> one RdEn pulse with Address=2; RdData_Valid next cycle; TX_D_VLD pulse with TX_P_DATA=81 (REG2 reset value) two cycles after the address byte.
3. Byte 55 in IDLE -> CMD_ERR one-cycle pulse; WrEn=RdEn=TX_D_VLD=0; BUSY stays 0.
4. BB,03 with FIFO_FULL held 1 for 5 cycles -> TX_D_VLD=0 and BUSY=1 throughout; after FIFO_FULL falls, exactly one TX_D_VLD with TX_P_DATA=20.
5. RdData_Valid tied 0, BB,01 -> CMD_ERR after 4 cycles in RD_WAIT; state returns to IDLE; no TX_D_VLD.
6. AA,07 then RST low for 2 cycles -> no WrEn, outputs 0; then AA,07,11 -> WrEn with Address=7, WrData=11.
